// File: rtl/md_issue_ctrl.sv
// Multiply/divide issue and hazard controller beside the EX stage.
// Issues MD ops, tracks latency, stalls on MD/HI-LO hazards.
module md_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic        rd_hilo,
    input  logic        rupt,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic        issue_ack,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             op_valid;
    logic             op_long;
    logic             op_mul;
    logic             issue;
    logic             last;

    always_comb begin
        op_valid = (req_op != 3'd0) && (req_op != 3'd7);
        op_long  = (req_op >= 3'd1) && (req_op <= 3'd4);
        op_mul   = (req_op == 3'd1) || (req_op == 3'd3);
        issue    = reset && (state_q == IDLE) && req_valid
                   && op_valid && !rupt;
        last     = (state_q == RUN) && (cnt_q == ONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (issue && op_long) begin
                    state_d = RUN;
                    cnt_d   = op_mul ? MUL_CNT : DIV_CNT;
                end
            end
            RUN: begin
                cnt_d = cnt_q - ONE;
                if (last) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Interrupts never reach the RUN stall term: the unit cannot abort.
    always_comb begin
        md_start  = issue && op_long;
        md_op     = issue ? req_op : 3'd0;
        issue_ack = issue;
        stall     = reset && (state_q == RUN)
                    && ((req_valid && op_valid) || rd_hilo);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            stall_cycles <= '0;
        end else begin
            busy <= (state_d == RUN);
            done <= last;
            if (stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule
